// File: rtl/mips_pkg.sv
// Shared MIPS core constants and the register-file write arbiter state type.
package mips_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STALL
    } wrarb_state_t;

endpackage

// File: rtl/wrarb_wait_ctr.sv
// Counts consecutive cycles an MDU request has lost the write port to WB.
// hit flags that the next increment brings the count to MAX_WAIT.
module wrarb_wait_ctr
    import mips_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned W        = $clog2(MAX_WAIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    logic [W-1:0] cnt;

    assign hit = (cnt == W'(MAX_WAIT - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != W'(MAX_WAIT))) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the single register-file write port between WB (priority) and the MDU,
// forcing a one-cycle pipeline stall once the MDU has lost MAX_WAIT times in a row.
module regfile_wr_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W   = mips_pkg::DATA_W,
    parameter int unsigned ADDR_W   = mips_pkg::ADDR_W,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mdu_valid,
    input  logic [ADDR_W-1:0] mdu_addr,
    input  logic [DATA_W-1:0] mdu_data,
    output logic              mdu_ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] writereg,
    output logic [DATA_W-1:0] writedata,
    output logic              pipe_stall
);

    wrarb_state_t      state, state_nxt;
    logic              wb_win, mdu_win, squash_ack;
    logic              ctr_clr, ctr_inc, ctr_hit;
    logic              squash;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    wrarb_wait_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_ctr (
        .clk (clk),
        .rst (rst),
        .clr (ctr_clr),
        .inc (ctr_inc),
        .hit (ctr_hit)
    );

    // Younger WB write to the same live register makes the MDU result dead.
    assign squash = mdu_valid && wb_we && (mdu_addr == wb_addr) && (wb_addr != '0);

    always_comb begin
        state_nxt  = state;
        wb_win     = 1'b0;
        mdu_win    = 1'b0;
        squash_ack = 1'b0;
        ctr_clr    = 1'b0;
        ctr_inc    = 1'b0;
        case (state)
            // IDLE and WAIT share arbitration; the counter is already zero in IDLE.
            IDLE, WAIT: begin
                if (!mdu_valid) begin
                    wb_win    = wb_we;
                    ctr_clr   = 1'b1;
                    state_nxt = IDLE;
                end else if (!wb_we) begin
                    mdu_win   = 1'b1;
                    ctr_clr   = 1'b1;
                    state_nxt = IDLE;
                end else if (squash) begin
                    wb_win     = 1'b1;
                    squash_ack = 1'b1;
                    ctr_clr    = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    wb_win    = 1'b1;
                    ctr_inc   = 1'b1;
                    state_nxt = ctr_hit ? STALL : WAIT;
                end
            end
            STALL: begin
                mdu_win   = mdu_valid;
                ctr_clr   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                ctr_clr   = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    assign win_addr   = mdu_win ? mdu_addr : wb_addr;
    assign win_data   = mdu_win ? mdu_data : wb_data;
    assign mdu_ready  = !rst && (mdu_win || squash_ack);
    assign pipe_stall = (state == STALL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            RegWrite  <= 1'b0;
            writereg  <= '0;
            writedata <= '0;
        end else begin
            state    <= state_nxt;
            RegWrite <= (wb_win || mdu_win) && (win_addr != '0);
            if (wb_win || mdu_win) begin
                writereg  <= win_addr;
                writedata <= win_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed and random checks of the register-file write arbiter against hand values and a spec model.
module tb_regfile_wr_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned MW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          mdu_valid;
    logic [AW-1:0] mdu_addr;
    logic [DW-1:0] mdu_data;
    logic          mdu_ready;
    logic          RegWrite;
    logic [AW-1:0] writereg;
    logic [DW-1:0] writedata;
    logic          pipe_stall;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic        prev_pending = 1'b0;

    regfile_wr_arbiter #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .MAX_WAIT (MW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .mdu_valid  (mdu_valid),
        .mdu_addr   (mdu_addr),
        .mdu_data   (mdu_data),
        .mdu_ready  (mdu_ready),
        .RegWrite   (RegWrite),
        .writereg   (writereg),
        .writedata  (writedata),
        .pipe_stall (pipe_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
        wb_we     = we;
        wb_addr   = wa;
        wb_data   = wd;
        mdu_valid = mv;
        mdu_addr  = ma;
        mdu_data  = md;
    endtask

    // MDU must hold its request until the handshake completes.
    always @(posedge clk) begin
        if (!rst && prev_pending)
            chk("mdu_hold", {31'd0, mdu_valid}, 32'd1);
        prev_pending <= mdu_valid && !mdu_ready;
    end

    initial begin
        logic          wwe, mv, stall_m, nxt_stall, exp_ready, exp_rw;
        logic [AW-1:0] wa, ma, exp_a;
        logic [DW-1:0] wd, md, exp_d;
        int unsigned   losses, waited;

        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        cyc();
        cyc();
        chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("rst_writereg", {27'd0, writereg}, 32'd0);
        chk("rst_writedata", writedata, 32'd0);
        chk("rst_stall", {31'd0, pipe_stall}, 32'd0);
        chk("rst_ready", {31'd0, mdu_ready}, 32'd0);
        rst = 1'b0;

        // 1: reset in the middle of a WAIT episode
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd7, 32'h55);
        #1 chk("t1_ready0", {31'd0, mdu_ready}, 32'd0);
        cyc();
        chk("t1_wb1_we", {31'd0, RegWrite}, 32'd1);
        chk("t1_wb1_addr", {27'd0, writereg}, 32'd1);
        drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd7, 32'h55);
        #1 chk("t1_ready1", {31'd0, mdu_ready}, 32'd0);
        cyc();
        rst = 1'b1;
        #1 chk("t1_ready_in_rst", {31'd0, mdu_ready}, 32'd0);
        cyc();
        cyc();
        cyc();
        chk("t1_rst_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("t1_rst_writereg", {27'd0, writereg}, 32'd0);
        chk("t1_rst_writedata", writedata, 32'd0);
        chk("t1_rst_stall", {31'd0, pipe_stall}, 32'd0);
        rst = 1'b0;
        wb_we = 1'b0;
        #1 chk("t1_regrant", {31'd0, mdu_ready}, 32'd1);
        chk("t1_no_stall", {31'd0, pipe_stall}, 32'd0);
        cyc();
        chk("t1_mdu_we", {31'd0, RegWrite}, 32'd1);
        chk("t1_mdu_addr", {27'd0, writereg}, 32'd7);
        chk("t1_mdu_data", writedata, 32'h55);

        // 2: plain WB writes, reg 0 suppressed
        drive(1'b1, 5'd5, 32'h0A, 1'b0, '0, '0);
        cyc();
        chk("t2_we", {31'd0, RegWrite}, 32'd1);
        chk("t2_addr", {27'd0, writereg}, 32'd5);
        chk("t2_data", writedata, 32'h0A);
        drive(1'b1, 5'd0, 32'h33, 1'b0, '0, '0);
        cyc();
        chk("t2_reg0_we", {31'd0, RegWrite}, 32'd0);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        cyc();
        chk("t2_idle_we", {31'd0, RegWrite}, 32'd0);

        // 3: MDU alone
        drive(1'b0, '0, '0, 1'b1, 5'd7, 32'h55);
        #1 chk("t3_ready", {31'd0, mdu_ready}, 32'd1);
        cyc();
        chk("t3_we", {31'd0, RegWrite}, 32'd1);
        chk("t3_addr", {27'd0, writereg}, 32'd7);
        chk("t3_data", writedata, 32'h55);

        // 4: MDU starved by WB until forced stall
        for (int unsigned i = 1; i <= 4; i++) begin
            drive(1'b1, 5'(i), 32'h100 + i, 1'b1, 5'd7, 32'h55);
            #1 chk("t4_ready_lose", {31'd0, mdu_ready}, 32'd0);
            chk("t4_stall_lose", {31'd0, pipe_stall}, 32'd0);
            cyc();
            chk("t4_wb_we", {31'd0, RegWrite}, 32'd1);
            chk("t4_wb_addr", {27'd0, writereg}, i);
            chk("t4_wb_data", writedata, 32'h100 + i);
        end
        drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd7, 32'h55);
        #1 chk("t4_stall", {31'd0, pipe_stall}, 32'd1);
        chk("t4_ready", {31'd0, mdu_ready}, 32'd1);
        cyc();
        chk("t4_mdu_we", {31'd0, RegWrite}, 32'd1);
        chk("t4_mdu_addr", {27'd0, writereg}, 32'd7);
        chk("t4_mdu_data", writedata, 32'h55);
        mdu_valid = 1'b0;
        #1 chk("t4_stall_clear", {31'd0, pipe_stall}, 32'd0);
        cyc();
        chk("t4_replay_addr", {27'd0, writereg}, 32'd6);
        chk("t4_replay_data", writedata, 32'h66);

        // 5: WAW squash
        drive(1'b1, 5'd9, 32'h20, 1'b1, 5'd9, 32'h99);
        #1 chk("t5_ready", {31'd0, mdu_ready}, 32'd1);
        cyc();
        chk("t5_we", {31'd0, RegWrite}, 32'd1);
        chk("t5_addr", {27'd0, writereg}, 32'd9);
        chk("t5_data", writedata, 32'h20);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        cyc();
        chk("t5_no_mdu", {31'd0, RegWrite}, 32'd0);

        // 6: random traffic against the behavioural model
        wwe = 1'b0; wa = '0; wd = '0;
        mv = 1'b0; ma = '0; md = '0;
        stall_m = 1'b0; exp_rw = 1'b0; exp_a = '0; exp_d = '0;
        losses = 0; waited = 0;
        for (int c = 0; c < 2000; c++) begin
            if (c > 0) begin
                chk("r_we", {31'd0, RegWrite}, {31'd0, exp_rw});
                if (exp_rw) begin
                    chk("r_addr", {27'd0, writereg}, {27'd0, exp_a});
                    chk("r_data", writedata, exp_d);
                end
            end
            if (!mv && ($urandom_range(0, 9) < 3)) begin
                mv = 1'b1;
                ma = 5'($urandom_range(0, 31));
                md = $urandom;
                waited = 0;
            end
            if (!stall_m) begin
                wwe = ($urandom_range(0, 9) < 7);
                wa  = 5'($urandom_range(0, 31));
                wd  = $urandom;
                if (mv && ($urandom_range(0, 4) == 0))
                    wa = ma;
            end
            drive(wwe, wa, wd, mv, ma, md);

            exp_ready = 1'b0;
            exp_rw    = 1'b0;
            nxt_stall = 1'b0;
            if (stall_m) begin
                exp_ready = 1'b1;
                exp_rw = (ma != 0); exp_a = ma; exp_d = md;
            end else if (mv && wwe && (wa == ma) && (wa != 0)) begin
                exp_ready = 1'b1;
                exp_rw = 1'b1; exp_a = wa; exp_d = wd;
            end else if (mv && !wwe) begin
                exp_ready = 1'b1;
                exp_rw = (ma != 0); exp_a = ma; exp_d = md;
            end else if (mv) begin
                exp_rw = (wa != 0); exp_a = wa; exp_d = wd;
                losses++;
                if (losses == MW)
                    nxt_stall = 1'b1;
            end else if (wwe) begin
                exp_rw = (wa != 0); exp_a = wa; exp_d = wd;
            end
            if (mv)
                waited++;

            #1 chk("r_ready", {31'd0, mdu_ready}, {31'd0, exp_ready});
            chk("r_stall", {31'd0, pipe_stall}, {31'd0, stall_m});
            if (exp_ready) begin
                chk("r_wait_bound", {31'd0, (waited <= MW + 1)}, 32'd1);
                mv = 1'b0;
                losses = 0;
            end
            stall_m = nxt_stall;
            cyc();
        end
        chk("r_last_we", {31'd0, RegWrite}, {31'd0, exp_rw});
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
